// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access load/store unit.
// Holds the opcode constants, funct3 width codes, FSM state enum and lane helpers.
package mem_access_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic load_ok(input logic [2:0] f3);
        unique case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: load_ok = 1'b1;
            default:                        load_ok = 1'b0;
        endcase
    endfunction

    function automatic logic store_ok(input logic [2:0] f3);
        unique case (f3)
            F3_B, F3_H, F3_W: store_ok = 1'b1;
            default:          store_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                              input logic [1:0] a);
        unique case (f3)
            F3_B:    store_strb = 4'b0001 << a;
            F3_H:    store_strb = a[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] d);
        unique case (f3)
            F3_B:    store_data = {4{d[7:0]}};
            F3_H:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // True when the access is not naturally aligned for its size.
    function automatic logic misalign(input logic [2:0] f3,
                                      input logic [1:0] a);
        unique case (f3)
            F3_H, F3_HU: misalign = a[0];
            F3_W:        misalign = (a != 2'b00);
            default:     misalign = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extract and sign/zero extension.
// Ports: rdata (bus word), addr_lo (byte offset), funct3 (width), data (result).
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = 8'h00;
        unique case (addr_lo)
            2'd0: sel_b = rdata[7:0];
            2'd1: sel_b = rdata[15:8];
            2'd2: sel_b = rdata[23:16];
            2'd3: sel_b = rdata[31:24];
            default: sel_b = 8'h00;
        endcase
        sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        unique case (funct3)
            F3_B:    data = {{24{sel_b[7]}}, sel_b};
            F3_BU:   data = {24'h0, sel_b};
            F3_H:    data = {{16{sel_h[15]}}, sel_h};
            F3_HU:   data = {16'h0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-bus load/store per request, with timeout.
// Ports: clk, rst (async active-low), valid_in/instruction/mem_alu_result/
// reg2_data in; mem_req/we/addr/wdata/wstrb out; mem_ready/rdata in;
// wb_data, done, busy, bus_err, misaligned out.
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] reg2_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        busy,
    output logic        bus_err,
    output logic        misaligned
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    addr_lo;
    logic [2:0]    f3_q;
    logic [31:0]   ld_data;

    logic [6:0] op;
    logic [2:0] f3;
    logic       is_ld;
    logic       is_st;
    logic       mis_hit;
    logic       timeout;
    logic       unused_bits;

    assign op      = instruction[6:0];
    assign f3      = instruction[14:12];
    assign is_ld   = (op == OP_LOAD) && load_ok(f3);
    assign is_st   = (op == OP_STORE) && store_ok(f3);
    // Abort on the edge the counter would reach MAX_WAIT.
    assign timeout = (MAX_WAIT != 0) && (cnt == LAST);

    assign unused_bits = ^{instruction[31:15], instruction[11:7]};

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis_hit    = (is_ld || is_st) && misalign(f3, mem_alu_result[1:0]);
    assign misaligned = mis_q;
`else
    assign mis_hit    = 1'b0;
    assign misaligned = 1'b0;
`endif

    load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo),
        .funct3  (f3_q),
        .data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_lo   <= 2'b00;
            f3_q      <= 3'b000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            wb_data   <= 32'h0;
            done      <= 1'b0;
            busy      <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        busy <= 1'b1;
                        if ((is_ld || is_st) && !mis_hit) begin
                            state     <= REQ;
                            cnt       <= '0;
                            addr_lo   <= mem_alu_result[1:0];
                            f3_q      <= f3;
                            mem_req   <= 1'b1;
                            mem_we    <= is_st;
                            mem_addr  <= {mem_alu_result[31:2], 2'b00};
                            mem_wstrb <= is_st ? store_strb(f3, mem_alu_result[1:0]) : 4'h0;
                            mem_wdata <= is_st ? store_data(f3, reg2_data) : 32'h0;
                        end else if (mis_hit) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wb_data <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
                            mis_q   <= 1'b1;
`endif
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wb_data <= mem_alu_result;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready || timeout) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'h0;
                        mem_wdata <= 32'h0;
                        // Ready wins over a simultaneous timeout.
                        if (mem_ready) begin
                            wb_data <= mem_we ? 32'h0 : ld_data;
                        end else begin
                            wb_data <= 32'h0;
                            bus_err <= 1'b1;
                            cnt     <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    bus_err <= 1'b0;
                    cnt     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    mis_q   <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus reset-abort sequence.
// Instantiates mem_access with MAX_WAIT=4 so the timeout path is reachable.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic [31:0] mem_alu_result = 32'h0;
    logic [31:0] reg2_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] wb_data;
    logic        done;
    logic        busy;
    logic        bus_err;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    mem_access #(.MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .instruction    (instruction),
        .mem_alu_result (mem_alu_result),
        .reg2_data      (reg2_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .wb_data        (wb_data),
        .done           (done),
        .busy           (busy),
        .bus_err        (bus_err),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          waits;
        int          e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic        e_err;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] rdata,
                       input int waits, input int e_req,
                       input logic [31:0] e_addr, input logic e_we,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_wb, input logic e_err,
                       input logic e_mis);
        vec_t v;
        v.instr = instr;   v.addr = addr;     v.rs2 = rs2;
        v.rdata = rdata;   v.waits = waits;   v.e_req = e_req;
        v.e_addr = e_addr; v.e_we = e_we;     v.e_strb = e_strb;
        v.e_wdata = e_wdata;
        v.e_wb = e_wb;     v.e_err = e_err;   v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge; returns the same way.
    task automatic run_vec(input int n, input vec_t v);
        int req_n;
        int done_at;
        req_n = 0;
        done_at = -1;
        instruction = v.instr;
        mem_alu_result = v.addr;
        reg2_data = v.rs2;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_at = i;
                break;
            end
            if (mem_req) begin
                if (req_n == 0) begin
                    chk($sformatf("v%0d_addr", n), mem_addr, v.e_addr);
                    chk($sformatf("v%0d_we", n), 32'(mem_we), 32'(v.e_we));
                    chk($sformatf("v%0d_strb", n), 32'(mem_wstrb), 32'(v.e_strb));
                    chk($sformatf("v%0d_wdata", n), mem_wdata, v.e_wdata);
                end
                req_n++;
                mem_ready = (req_n > v.waits);
                mem_rdata = v.rdata;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        chk($sformatf("v%0d_req_cycles", n), 32'(req_n), 32'(v.e_req));
        chk($sformatf("v%0d_done_at", n), 32'(done_at), 32'(v.e_req));
        chk($sformatf("v%0d_wb", n), wb_data, v.e_wb);
        chk($sformatf("v%0d_err", n), 32'(bus_err), 32'(v.e_err));
        chk($sformatf("v%0d_mis", n), 32'(misaligned), 32'(v.e_mis));
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_drop", n), 32'({done, busy}), 32'h0);
    endtask

    initial begin
        // name: LW 3 waits
        add(32'h00002003, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4,
            32'h100, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        add(32'h00000003, 32'h203, 32'h0, 32'h80FF1234, 0, 1,
            32'h200, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        add(32'h00004003, 32'h203, 32'h0, 32'h80FF1234, 0, 1,
            32'h200, 1'b0, 4'h0, 32'h0, 32'h00000080, 1'b0, 1'b0);
        add(32'h00001023, 32'h302, 32'h0000ABCD, 32'h0, 1, 2,
            32'h300, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
        add(32'h00000033, 32'h55, 32'h0, 32'h0, 0, 0,
            32'h0, 1'b0, 4'h0, 32'h0, 32'h55, 1'b0, 1'b0);
        add(32'h00002003, 32'h400, 32'h0, 32'h12345678, 99, 4,
            32'h400, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        add(32'h00001003, 32'h106, 32'h0, 32'h80017FFF, 2, 3,
            32'h104, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
        add(32'h00005003, 32'h104, 32'h0, 32'h12349ABC, 0, 1,
            32'h104, 1'b0, 4'h0, 32'h0, 32'h00009ABC, 1'b0, 1'b0);
        add(32'h00000023, 32'h501, 32'h123456A5, 32'h0, 0, 1,
            32'h500, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        add(32'h00002023, 32'h600, 32'hCAFEF00D, 32'h0, 0, 1,
            32'h600, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        add(32'h00003003, 32'h777, 32'h0, 32'h0, 0, 0,
            32'h0, 1'b0, 4'h0, 32'h0, 32'h777, 1'b0, 1'b0);
        add(32'h00004023, 32'h88, 32'h0, 32'h0, 0, 0,
            32'h0, 1'b0, 4'h0, 32'h0, 32'h88, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        add(32'h00002003, 32'h101, 32'h0, 32'h11223344, 0, 0,
            32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
`else
        add(32'h00002003, 32'h101, 32'h0, 32'h11223344, 0, 1,
            32'h100, 1'b0, 4'h0, 32'h0, 32'h11223344, 1'b0, 1'b0);
`endif

        #1 rst = 1'b0;
        #2;
        chk("rst_req_we", 32'({mem_req, mem_we}), 32'h0);
        chk("rst_flags", 32'({done, busy, bus_err, misaligned}), 32'h0);
        chk("rst_wb", wb_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset in the middle of a load: request drops at once, no done.
        instruction = 32'h00002003;
        mem_alu_result = 32'h100;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("abort_req_on", 32'(mem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("abort_req_off", 32'({mem_req, busy, done}), 32'h0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            chk("abort_no_done", 32'(seen), 32'h0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
